// File: rtl/key_capture_pkg.sv
// Shared types and constants for the four-key capture block: FSM states,
// the default debounce period and a lowest-set-bit helper.
package key_capture_pkg;

  localparam int NUM_KEYS                = 4;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HOLD    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  // Isolates the lowest set bit so the lowest-index key wins.
  function automatic logic [NUM_KEYS-1:0] lowest_one_hot(input logic [NUM_KEYS-1:0] v);
    return v & (~v + NUM_KEYS'(1));
  endfunction

endpackage

// File: rtl/debounce_1.sv
// One key: 2-flop synchronizer, then a level that only changes after the
// synchronized input has disagreed with it for DEBOUNCE_CYCLES cycles in a row.
module debounce_1 #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic stable
);

  localparam int             CW   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_reg;
  logic          sync2_reg;
  logic          stable_reg;
  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_reg  <= 1'b0;
      sync2_reg  <= 1'b0;
      stable_reg <= 1'b0;
      cnt_reg    <= '0;
    end else begin
      sync1_reg <= key;
      sync2_reg <= sync1_reg;
      // Counter tracks consecutive disagreeing cycles; any agreement restarts it.
      if (sync2_reg == stable_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == LAST) begin
        stable_reg <= sync2_reg;
        cnt_reg    <= '0;
      end else begin
        cnt_reg <= cnt_reg + CW'(1);
      end
    end
  end

  assign stable = stable_reg;

endmodule

// File: rtl/key_capture_4.sv
// Debounces four keys, captures the lowest-index fresh press as a one-hot
// code and holds it until acknowledged, then waits for all keys released.
module key_capture_4
  import key_capture_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_in,
  input  logic                ack,
  output logic [NUM_KEYS-1:0] a,
  output logic                en
);

  logic [NUM_KEYS-1:0] stable;
  logic [NUM_KEYS-1:0] stable_prev_reg;
  logic [NUM_KEYS-1:0] rise;
  logic [NUM_KEYS-1:0] a_reg;
  logic                en_reg;
  state_t              state_reg;

  generate
    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
      debounce_1 #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
        .clk   (clk),
        .rst   (rst),
        .key   (key_in[gi]),
        .stable(stable[gi])
      );
    end
  endgenerate

  // Only a 0->1 edge of the debounced level counts as a press.
  assign rise = stable & ~stable_prev_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      stable_prev_reg <= '0;
      state_reg       <= IDLE;
      a_reg           <= '0;
      en_reg          <= 1'b0;
    end else begin
      stable_prev_reg <= stable;
      case (state_reg)
        IDLE: begin
          if (|rise) begin
            a_reg     <= lowest_one_hot(rise);
            en_reg    <= 1'b1;
            state_reg <= HOLD;
          end
        end
        HOLD: begin
          if (ack) begin
            a_reg     <= '0;
            en_reg    <= 1'b0;
            state_reg <= RELEASE;
          end
        end
        RELEASE: begin
          if (stable == '0) begin
            state_reg <= IDLE;
          end
        end
        default: begin
          a_reg     <= '0;
          en_reg    <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign a  = a_reg;
  assign en = en_reg;

endmodule

// File: tb/tb_key_capture_4.sv
// Self-checking bench for key_capture_4 with DEBOUNCE_CYCLES=4: vector table,
// directed corner sequences and random stimulus against a window-based model.
module tb_key_capture_4;
  import key_capture_pkg::*;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] key_in = 4'b0000;
  logic       ack = 1'b0;
  logic [3:0] a;
  logic       en;

  always #5 clk = ~clk;

  key_capture_4 #(.DEBOUNCE_CYCLES(D)) dut (
    .clk   (clk),
    .rst   (rst),
    .key_in(key_in),
    .ack   (ack),
    .a     (a),
    .en    (en)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: hist[k] is key_in as sampled k+1 edges ago. A key's
  // accepted level flips once the D synchronized samples all oppose it.
  logic [3:0] hist [0:D];
  logic [3:0] m_stable, m_prev, m_a;
  logic       m_en;
  int         m_mode;   // 0 waiting for press, 1 presenting, 2 waiting for release

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic model_edge(input logic r, input logic [3:0] k, input logic ak);
    logic [3:0] rise;
    logic [3:0] new_stable;
    bit         all_opp;
    int         pick;
    if (r) begin
      for (int j = 0; j <= D; j++) hist[j] = 4'b0000;
      m_stable = 4'b0000;
      m_prev   = 4'b0000;
      m_a      = 4'b0000;
      m_en     = 1'b0;
      m_mode   = 0;
    end else begin
      rise = m_stable & ~m_prev;
      for (int i = 0; i < 4; i++) begin
        all_opp = 1'b1;
        for (int j = 1; j <= D; j++)
          if (hist[j][i] == m_stable[i]) all_opp = 1'b0;
        new_stable[i] = all_opp ? ~m_stable[i] : m_stable[i];
      end
      for (int j = D; j >= 1; j--) hist[j] = hist[j-1];
      hist[0] = k;
      case (m_mode)
        0: if (rise != 4'b0000) begin
          pick = 0;
          for (int i = 3; i >= 0; i--) if (rise[i]) pick = i;
          m_a    = 4'b0000;
          m_a[pick] = 1'b1;
          m_en   = 1'b1;
          m_mode = 1;
        end
        1: if (ak) begin
          m_a    = 4'b0000;
          m_en   = 1'b0;
          m_mode = 2;
        end
        default: if (m_stable == 4'b0000) m_mode = 0;
      endcase
      m_prev   = m_stable;
      m_stable = new_stable;
    end
  endtask

  task automatic cyc(input logic r, input logic [3:0] k, input logic ak);
    rst    = r;
    key_in = k;
    ack    = ak;
    @(posedge clk);
    model_edge(r, k, ak);
    #1;
    check("model", 32'({en, a}), 32'({m_en, m_a}));
  endtask

  // Runs n cycles and returns whether en was ever seen high.
  task automatic run(input logic [3:0] k, input logic ak, input int n, output logic seen);
    seen = 1'b0;
    for (int c = 0; c < n; c++) begin
      cyc(1'b0, k, ak);
      seen |= en;
    end
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] key;
    logic       ack;
    logic       en;
    logic [3:0] a;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [3:0] k, input logic ak,
                     input logic e, input logic [3:0] aa, input int n);
    vec_t v;
    v.rst = r; v.key = k; v.ack = ak; v.en = e; v.a = aa;
    for (int c = 0; c < n; c++) vecs.push_back(v);
  endtask

  initial begin
    logic seen;
    logic a_bad;

    // Basic capture / ack / release / recapture, one row per edge.
    add(1, 4'b0000, 0, 0, 4'b0000, 1);
    add(0, 4'b0100, 0, 0, 4'b0000, 6);
    add(0, 4'b0100, 0, 1, 4'b0100, 1);   // edge 7
    add(0, 4'b0100, 1, 0, 4'b0000, 1);
    add(0, 4'b0100, 0, 0, 4'b0000, 1);
    add(0, 4'b0000, 0, 0, 4'b0000, 8);
    add(0, 4'b0010, 0, 0, 4'b0000, 6);
    add(0, 4'b0010, 0, 1, 4'b0010, 1);
    add(0, 4'b0010, 1, 0, 4'b0000, 1);
    foreach (vecs[i]) begin
      cyc(vecs[i].rst, vecs[i].key, vecs[i].ack);
      check($sformatf("vec%0d", i), 32'({en, a}), 32'({vecs[i].en, vecs[i].a}));
    end

    // Simultaneous rise: lowest index only, no later capture of key 3.
    cyc(1'b1, 4'b0000, 1'b0);
    check("reset_state", 32'({en, a}), 32'h0);
    run(4'b1010, 1'b0, 6, seen);
    check("simul_early", 32'(seen), 32'h0);
    cyc(1'b0, 4'b1010, 1'b0);
    check("simul_low", 32'({en, a}), 32'h12);
    cyc(1'b0, 4'b1010, 1'b1);
    check("simul_ack", 32'(en), 32'h0);
    run(4'b0000, 1'b0, 20, seen);
    check("no_requeue", 32'(seen), 32'h0);

    // Glitch shorter than the debounce period.
    run(4'b0001, 1'b0, 3, seen);
    check("glitch_hi", 32'(seen), 32'h0);
    run(4'b0000, 1'b0, 15, seen);
    check("glitch_lo", 32'(seen), 32'h0);

    // Press during HOLD ignored; RELEASE waits for every key.
    cyc(1'b1, 4'b0000, 1'b0);
    run(4'b0001, 1'b0, 6, seen);
    cyc(1'b0, 4'b0001, 1'b0);
    check("key0_cap", 32'({en, a}), 32'h11);
    a_bad = 1'b0;
    for (int c = 0; c < 8; c++) begin
      cyc(1'b0, 4'b0101, 1'b0);
      if (a !== 4'b0001 || en !== 1'b1) a_bad = 1'b1;
    end
    check("hold_const", 32'(a_bad), 32'h0);
    cyc(1'b0, 4'b0101, 1'b1);
    check("hold_ack", 32'(en), 32'h0);
    run(4'b0100, 1'b0, 8, seen);
    run(4'b0101, 1'b0, 10, seen);
    check("release_wait", 32'(seen), 32'h0);
    run(4'b0000, 1'b0, 8, seen);
    run(4'b1000, 1'b0, 6, seen);
    cyc(1'b0, 4'b1000, 1'b0);
    check("after_release", 32'({en, a}), 32'h18);

    // Reset mid-HOLD, then recapture of the still-held key.
    cyc(1'b1, 4'b1000, 1'b0);
    check("rst_mid_hold", 32'({en, a}), 32'h0);
    run(4'b1000, 1'b0, 6, seen);
    check("rst_recap_early", 32'(seen), 32'h0);
    cyc(1'b0, 4'b1000, 1'b0);
    check("rst_recap", 32'({en, a}), 32'h18);

    // ack held high from IDLE: en lasts exactly one cycle.
    cyc(1'b1, 4'b0000, 1'b1);
    run(4'b1000, 1'b1, 6, seen);
    cyc(1'b0, 4'b1000, 1'b1);
    check("ack_idle_cap", 32'({en, a}), 32'h18);
    cyc(1'b0, 4'b1000, 1'b1);
    check("ack_one_cycle", 32'(en), 32'h0);
    run(4'b1000, 1'b1, 10, seen);
    check("ack_no_more", 32'(seen), 32'h0);

    // Random stimulus against the model.
    cyc(1'b1, 4'b0000, 1'b0);
    begin
      logic [3:0] k = 4'b0000;
      for (int c = 0; c < 4000; c++) begin
        if ($urandom_range(0, 7) == 0) k = 4'($urandom);
        cyc($urandom_range(0, 499) == 0, k, $urandom_range(0, 3) == 0);
        if (!$onehot0(a)) check("onehot", 32'(a), 32'h0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
